// File: rtl/psum_collector.sv
// psum_collector: reader at the bottom edge of the systolic PE array.
// It takes skewed partial sums from the last PE row, where column c arrives
// one cycle after column c-1. It deskews them into whole result rows and
// buffers those rows in a small FIFO. Rows leave on a valid/ready handshake.
//
// Optional feature, macro PSUM_COLLECT_RELU_EN: when defined, each column is
// clamped to zero at the FIFO write if its sign bit is set. This adds no
// latency.
//
// Handshake: a row transfers at any clock edge where out_valid && out_ready.
// out_valid is high exactly when the FIFO is not empty. out_data is the FIFO
// head and holds steady until the row is popped. out_ready is ignored while
// the FIFO is empty.

`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

module psum_collector #(
    parameter int ARRAY_W    = 5,
    parameter int DATA_W     = `DATA_SIZE,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [ARRAY_W*DATA_W-1:0]         in_data,
    input  logic                              clear,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ARRAY_W*DATA_W-1:0]         out_data,
    output logic [$clog2(FIFO_DEPTH):0]       count,
    output logic                              overflow,
    output logic [15:0]                       row_cnt
);

    localparam int RW = ARRAY_W * DATA_W;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    // The deskew line has one row-wide register per stage, stage s = 1..ARRAY_W-1.
    // Stage s holds columns 0..s-1 of the row whose tag sits in vld_q[s].
    // Its upper columns stay zero.
    logic [ARRAY_W-1:1] vld_q, vld_d;
    logic [RW-1:0]      row_q [1:ARRAY_W-1];
    logic [RW-1:0]      row_d [1:ARRAY_W-1];

    // FIFO storage and bookkeeping
    logic [RW-1:0]      mem_q [FIFO_DEPTH];
    logic [RW-1:0]      mem_d [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        row_cnt_q, row_cnt_d;

    logic [RW-1:0]      aligned_row;
    logic [RW-1:0]      wr_row;
    logic               push_req;
    logic               full;
    logic               pop;
    logic               push_ok;

    // Shift the row tags. Each column is captured only in its tagged cycle.
    always_comb begin
        vld_d = vld_q;
        for (int s = 1; s < ARRAY_W; s++) begin
            row_d[s] = row_q[s];
        end
        if (clear) begin
            vld_d = '0;
        end else begin
            vld_d[1] = in_valid;
            for (int s = 2; s < ARRAY_W; s++) begin
                vld_d[s] = vld_q[s-1];
            end
        end
        if (in_valid && !clear) begin
            row_d[1] = '0;
            row_d[1][DATA_W-1:0] = in_data[DATA_W-1:0];
        end
        for (int s = 1; s < ARRAY_W - 1; s++) begin
            if (vld_q[s]) begin
                row_d[s+1] = row_q[s];
                row_d[s+1][s*DATA_W +: DATA_W] = in_data[s*DATA_W +: DATA_W];
            end
        end
    end

    // Complete the row. The last column comes straight from the bus in the final tagged cycle.
    always_comb begin
        aligned_row = row_q[ARRAY_W-1];
        aligned_row[(ARRAY_W-1)*DATA_W +: DATA_W] = in_data[(ARRAY_W-1)*DATA_W +: DATA_W];
        push_req = vld_q[ARRAY_W-1] && !clear;
    end

`ifdef PSUM_COLLECT_RELU_EN
    // Clamp negative columns to zero on the way into the FIFO.
    always_comb begin
        wr_row = aligned_row;
        for (int c = 0; c < ARRAY_W; c++) begin
            if (aligned_row[c*DATA_W + DATA_W - 1]) begin
                wr_row[c*DATA_W +: DATA_W] = '0;
            end
        end
    end
`else
    // Rows are stored unmodified.
    always_comb begin
        wr_row = aligned_row;
    end
`endif

    // FIFO push/pop. A push to a full FIFO succeeds only if a pop happens on the same edge.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        row_cnt_d  = row_cnt_q;
        full       = (count_q == CW'(FIFO_DEPTH));
        pop        = (count_q != '0) && out_ready;
        push_ok    = push_req && (!full || pop);
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            row_cnt_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push_ok) begin
                mem_d[wr_ptr_q] = wr_row;
                wr_ptr_d        = wr_ptr_q + AW'(1);
                row_cnt_d       = row_cnt_q + 16'd1;
            end
            if (push_req && !push_ok) begin
                overflow_d = 1'b1;
            end
            count_d = count_q + CW'(push_ok) - CW'(pop);
        end
    end

    // State registers. Reset clears every row tag, data register and pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            for (int s = 1; s < ARRAY_W; s++) begin
                row_q[s] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            row_cnt_q  <= '0;
        end else begin
            vld_q      <= vld_d;
            for (int s = 1; s < ARRAY_W; s++) begin
                row_q[s] <= row_d[s];
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            row_cnt_q  <= row_cnt_d;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign row_cnt   = row_cnt_q;

endmodule

// File: tb/tb_psum_collector.sv
// Testbench for psum_collector.
// The reference model records the input bus every cycle. It rebuilds each
// tagged row from that history: column c comes from the bus c cycles after
// the tag. The model holds the buffered rows in a queue.

`ifndef DATA_SIZE
`define DATA_SIZE 16
`endif

module tb_psum_collector;

    localparam int W    = 5;
    localparam int DW   = 16;
    localparam int D    = 4;
    localparam int RW   = W * DW;
    localparam int CW   = $clog2(D) + 1;
    localparam int NCYC = 1024;
    localparam int SLEN = 32;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [RW-1:0] in_data;
    logic          clear;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   row_cnt;

    psum_collector #(.ARRAY_W(W), .DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .row_cnt   (row_cnt)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] hist [0:NCYC-1];
    bit            tagv [0:NCYC-1];
    int            cyc      = 0;
    int            last_clr = -1;
    logic          m_ovf    = 1'b0;
    logic [15:0]   m_rcnt   = '0;

    int n_chk  = 0;
    int n_fail = 0;

    // Stimulus schedule for the directed tests
    logic [RW-1:0] sched     [0:SLEN-1];
    bit            sched_v   [0:SLEN-1];
    bit            sched_clr [0:SLEN-1];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (model cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef PSUM_COLLECT_RELU_EN
        return ($signed(v) < 0) ? '0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [RW-1:0] rand_word();
        logic [RW-1:0] w;
        for (int c = 0; c < W; c++) w[c*DW +: DW] = DW'($urandom);
        return w;
    endfunction

    // Advance the model by one clock edge, using the inputs driven for that edge
    task automatic model_edge();
        int            t;
        bit            done;
        bit            pop;
        bit            was_full;
        logic [RW-1:0] row;
        hist[cyc] = in_data;
        tagv[cyc] = in_valid && !clear;
        pop = (exp_q.size() != 0) && out_ready;
        if (clear) begin
            exp_q.delete();
            m_ovf    = 1'b0;
            m_rcnt   = '0;
            last_clr = cyc;
        end else begin
            t        = cyc - (W - 1);
            done     = (t >= 0) && tagv[t] && (last_clr < t);
            was_full = (exp_q.size() == D);
            if (pop) void'(exp_q.pop_front());
            if (done) begin
                if (!was_full || pop) begin
                    for (int c = 0; c < W; c++) row[c*DW +: DW] = relu(hist[t+c][c*DW +: DW]);
                    exp_q.push_back(row);
                    m_rcnt = m_rcnt + 16'd1;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        cyc++;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, exp_q.size() != 0);
        check("count", count, exp_q.size());
        check("overflow", overflow, m_ovf);
        check("row_cnt", row_cnt, m_rcnt);
        if (exp_q.size() != 0) check("out_data", out_data, exp_q[0]);
    endtask

    // One clock: inputs are already driven; update the model at the edge and check at the falling edge
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic clear_sched();
        for (int i = 0; i < SLEN; i++) begin
            sched[i]     = rand_word();
            sched_v[i]   = 1'b0;
            sched_clr[i] = 1'b0;
        end
    endtask

    task automatic place_row(input int s, input int base);
        sched_v[s] = 1'b1;
        for (int c = 0; c < W; c++) sched[s+c][c*DW +: DW] = DW'(base + c);
    endtask

    function automatic logic ready_of(input int mode, input int i);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (i % 4 == 0) || (i % 4 == 3);
            4:       return (i == 10);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic run(input int len, input int mode);
        for (int i = 0; i < len; i++) begin
            in_valid  = sched_v[i];
            in_data   = sched[i];
            clear     = sched_clr[i];
            out_ready = ready_of(mode, i);
            step();
        end
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic drain(input int len);
        clear_sched();
        run(len, 1);
    endtask

    task automatic do_clear();
        clear_sched();
        sched_clr[0] = 1'b1;
        run(1, 0);
    endtask

    initial begin
        logic [RW-1:0] exp_row;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        clear     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_row_cnt", row_cnt, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;

        // Single row, columns 10..14
        clear_sched();
        place_row(0, 10);
        run(5, 0);
        for (int c = 0; c < W; c++) exp_row[c*DW +: DW] = DW'(10 + c);
        check("single_valid", out_valid, 1'b1);
        check("single_data", out_data, exp_row);
        check("single_row_cnt", row_cnt, 1);
        check("single_count", count, 1);
        drain(3);

        // Back-to-back rows with the sink always ready
        clear_sched();
        for (int r = 0; r < 4; r++) place_row(r, 16 * r);
        run(12, 1);
        check("b2b_count", count, 0);
        check("b2b_overflow", overflow, 1'b0);

        // Overflow: five rows with no sink
        do_clear();
        clear_sched();
        for (int r = 0; r < 5; r++) place_row(r, 64 + 16 * r);
        run(10, 0);
        check("ovf_count", count, 4);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_row_cnt", row_cnt, 4);
        drain(8);
        check("ovf_sticky", overflow, 1'b1);

        // Push and pop on the same edge while full
        do_clear();
        clear_sched();
        place_row(0, 160);
        place_row(1, 176);
        place_row(2, 192);
        place_row(3, 208);
        place_row(6, 224);
        run(11, 4);
        check("pp_count", count, 4);
        check("pp_overflow", overflow, 1'b0);
        drain(8);
        check("pp_row_cnt", row_cnt, 5);

        // Backpressure pattern 1,0,0,1
        clear_sched();
        for (int r = 0; r < 4; r++) place_row(r, 256 + 16 * r);
        run(20, 2);

        // Clear two cycles after a row starts
        clear_sched();
        place_row(0, 512);
        sched_clr[2] = 1'b1;
        run(10, 1);
        check("clr_count", count, 0);
        check("clr_row_cnt", row_cnt, 0);

        // Negative column handling
        clear_sched();
        sched_v[0] = 1'b1;
        for (int c = 0; c < W; c++) sched[c][c*DW +: DW] = '0;
        sched[0][DW-1:0]    = 16'hFFF6;
        sched[1][2*DW-1:DW] = 16'd5;
        run(5, 0);
`ifdef PSUM_COLLECT_RELU_EN
        check("relu_col0", out_data[DW-1:0], 16'h0000);
`else
        check("relu_col0", out_data[DW-1:0], 16'hFFF6);
`endif
        check("relu_col1", out_data[2*DW-1:DW], 16'd5);
        drain(3);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = rand_word();
            clear     = ($urandom_range(0, 39) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        clear    = 1'b0;

        // Asynchronous reset with rows buffered and in flight
        clear_sched();
        for (int r = 0; r < 3; r++) place_row(r, 768 + 16 * r);
        run(6, 0);
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_count", count, 0);
        check("arst_overflow", overflow, 1'b0);
        check("arst_row_cnt", row_cnt, 0);
        check("arst_out_data", out_data, 0);
        #1;
        rst = 1'b0;
        exp_q.delete();
        m_ovf    = 1'b0;
        m_rcnt   = '0;
        last_clr = cyc - 1;
        drain(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
